// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between two requesters:
//   port A - core load/store path (core_stall tells the core to wait)
//   port B - loader/debug path
// Each access owns the memory for MEM_LATENCY cycles (gnt high), then the
// port gets a one-cycle ack with read data. Round-robin between the ports
// when both are eligible in the same IDLE cycle.
//
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   a_* / b_*             : requester ports (req/we/addr/wdata in,
//                           gnt/ack/rdata out)
//   core_stall            : a_req & ~a_ack
//   mem_*                 : memory pins (address, write_data, memwrite out,
//                           read_data in)
//   perf_*                : 16-bit saturating event counters
//
// Optional feature: define DMEM_ARBITER_PERF_EN to build the perf counters;
// otherwise the perf_* outputs are tied to 0.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,   // 1..15
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  core_stall,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_memwrite,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [15:0]           perf_a_grants,
    output logic [15:0]           perf_b_grants,
    output logic [15:0]           perf_conflicts
);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t     state, state_nxt;
    logic       last_winner;   // 0 = A, 1 = B
    logic [3:0] cnt;
    logic       lat_we;        // latched write flag; writes return 0 data
    logic       elig_a, elig_b;
    logic       grant_a, grant_b, done;

    // A port acked this cycle is masked so a still-held request is not
    // re-granted as if it were new.
    assign elig_a = a_req & ~a_ack;
    assign elig_b = b_req & ~b_ack;

    assign a_gnt      = (state == BUSY_A);
    assign b_gnt      = (state == BUSY_B);
    assign core_stall = a_req & ~a_ack;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (elig_a && (!elig_b || last_winner)) begin
                    grant_a   = 1'b1;
                    state_nxt = BUSY_A;
                end else if (elig_b) begin
                    grant_b   = 1'b1;
                    state_nxt = BUSY_B;
                end
            end
            BUSY_A, BUSY_B: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_winner    <= 1'b1;
            cnt            <= 4'd0;
            lat_we         <= 1'b0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_memwrite   <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (grant_a || grant_b) begin
                mem_address    <= grant_a ? a_addr  : b_addr;
                mem_write_data <= grant_a ? a_wdata : b_wdata;
                mem_memwrite   <= grant_a ? a_we    : b_we;
                lat_we         <= grant_a ? a_we    : b_we;
                last_winner    <= grant_b;
                cnt            <= CNT_INIT;
            end else if (state != IDLE) begin
                // Write strobe lasts only the first BUSY cycle.
                mem_memwrite <= 1'b0;
                if (!done) begin
                    cnt <= cnt - 4'd1;
                end else if (state == BUSY_A) begin
                    a_ack   <= 1'b1;
                    a_rdata <= lat_we ? '0 : mem_read_data;
                end else begin
                    b_ack   <= 1'b1;
                    b_rdata <= lat_we ? '0 : mem_read_data;
                end
            end
        end
    end

`ifdef DMEM_ARBITER_PERF_EN
    logic conflict;
    assign conflict = (state == IDLE) && elig_a && elig_b;

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_a_grants  <= 16'd0;
            perf_b_grants  <= 16'd0;
            perf_conflicts <= 16'd0;
        end else begin
            if (grant_a && perf_a_grants != 16'hFFFF)
                perf_a_grants <= perf_a_grants + 16'd1;
            if (grant_b && perf_b_grants != 16'hFFFF)
                perf_b_grants <= perf_b_grants + 16'd1;
            if (conflict && perf_conflicts != 16'hFFFF)
                perf_conflicts <= perf_conflicts + 16'd1;
        end
    end
`else
    assign perf_a_grants  = 16'd0;
    assign perf_b_grants  = 16'd0;
    assign perf_conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at MEM_LATENCY=1 driven by a
// per-cycle vector table, one at MEM_LATENCY=3 exercised by hand-written
// multi-cycle sequences. Both share the requester inputs; each has its own
// small memory model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;

    logic        u1_a_gnt, u1_a_ack, u1_b_gnt, u1_b_ack, u1_core_stall, u1_mw;
    logic [31:0] u1_a_rdata, u1_b_rdata, u1_maddr, u1_mwdata, u1_mrdata;
    logic [15:0] u1_pa, u1_pb, u1_pc;
    logic        u3_a_gnt, u3_a_ack, u3_b_gnt, u3_b_ack, u3_core_stall, u3_mw;
    logic [31:0] u3_a_rdata, u3_b_rdata, u3_maddr, u3_mwdata, u3_mrdata;
    logic [15:0] u3_pa, u3_pb, u3_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MEM_LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u1 (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(u1_a_gnt), .a_ack(u1_a_ack), .a_rdata(u1_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(u1_b_gnt), .b_ack(u1_b_ack), .b_rdata(u1_b_rdata),
        .core_stall(u1_core_stall),
        .mem_address(u1_maddr), .mem_write_data(u1_mwdata),
        .mem_memwrite(u1_mw), .mem_read_data(u1_mrdata),
        .perf_a_grants(u1_pa), .perf_b_grants(u1_pb), .perf_conflicts(u1_pc)
    );

    dmem_arbiter #(.MEM_LATENCY(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u3 (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(u3_a_gnt), .a_ack(u3_a_ack), .a_rdata(u3_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(u3_b_gnt), .b_ack(u3_b_ack), .b_rdata(u3_b_rdata),
        .core_stall(u3_core_stall),
        .mem_address(u3_maddr), .mem_write_data(u3_mwdata),
        .mem_memwrite(u3_mw), .mem_read_data(u3_mrdata),
        .perf_a_grants(u3_pa), .perf_b_grants(u3_pb), .perf_conflicts(u3_pc)
    );

    // Memory models: preset contents come from init_val until a location
    // is written.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h14:   return 32'h11112222;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mem1 [0:255];
    bit          wr1  [0:255];
    logic [31:0] mem3 [0:255];
    bit          wr3  [0:255];

    always @(posedge clock) begin
        if (u1_mw) begin
            mem1[u1_maddr[7:0]] <= u1_mwdata;
            wr1[u1_maddr[7:0]]  <= 1'b1;
        end
        if (u3_mw) begin
            mem3[u3_maddr[7:0]] <= u3_mwdata;
            wr3[u3_maddr[7:0]]  <= 1'b1;
        end
    end

    assign u1_mrdata = wr1[u1_maddr[7:0]] ? mem1[u1_maddr[7:0]] : init_val(u1_maddr[7:0]);
    assign u3_mrdata = wr3[u3_maddr[7:0]] ? mem3[u3_maddr[7:0]] : init_val(u3_maddr[7:0]);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // exp bits: {a_gnt, a_ack, b_gnt, b_ack, core_stall, mem_memwrite}
    typedef struct {
        logic        rst;
        logic        a_req, a_we;
        logic [31:0] a_addr, a_wdata;
        logic        b_req, b_we;
        logic [31:0] b_addr, b_wdata;
        logic [5:0]  exp;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ar, input logic aw,
                                input logic [31:0] aa, input logic [31:0] ad,
                                input logic br, input logic bw,
                                input logic [31:0] ba, input logic [31:0] bd,
                                input logic [5:0] e, input logic [31:0] er);
        vec_t v;
        v.rst = rst; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        v.exp = e; v.exp_rdata = er;
        return v;
    endfunction

    localparam int NV = 23;
    vec_t tbl [NV];

    // One L=3 access on port A (pb=0) or B (pb=1); reports the cycle offset
    // of the ack, number of write strobes, grant cycles and strobe offset.
    task automatic run3(input bit pb, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int ack_k,
                        output int nw, output int ng, output int mwk);
        ack_k = -1; nw = 0; ng = 0; mwk = -1;
        @(negedge clock);
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        for (int k = 0; k < 20; k++) begin
            #1;
            if (u3_mw) begin nw++; mwk = k; end
            if (pb ? u3_b_gnt : u3_a_gnt) ng++;
            if (pb ? u3_b_ack : u3_a_ack) begin ack_k = k; break; end
            @(negedge clock);
        end
        a_req = 0; b_req = 0;
    endtask

    // Both ports raise a read together and each drops on its own ack.
    task automatic round3(input int r);
        bit sa, sb;
        sa = 0; sb = 0;
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 32'h40;
        b_req = 1; b_we = 0; b_addr = 32'h44;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (u3_a_ack) begin a_req = 0; sa = 1; end
            if (u3_b_ack) begin b_req = 0; sb = 1; end
            if (sa && sb) break;
            @(negedge clock);
        end
        chk($sformatf("round%0d_done", r), 64'(sa & sb), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_k, nw, ng, mwk, acks;
        logic [5:0] got;

        //                rst ar aw aa     ad  br bw ba     bd          exp        rdata
        tbl[0]  = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);
        tbl[1]  = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);
        tbl[2]  = mk(1, 1, 0, 'h10,  0, 0, 0, 0,     0,          6'b000010, 0);
        tbl[3]  = mk(1, 1, 0, 'h10,  0, 0, 0, 0,     0,          6'b100010, 0);
        tbl[4]  = mk(1, 1, 0, 'h10,  0, 0, 0, 0,     0,          6'b010000, 'hDEADBEEF);
        tbl[5]  = mk(1, 1, 0, 'h14,  0, 0, 0, 0,     0,          6'b000010, 0);
        tbl[6]  = mk(1, 1, 0, 'h14,  0, 0, 0, 0,     0,          6'b100010, 0);
        tbl[7]  = mk(1, 1, 0, 'h14,  0, 0, 0, 0,     0,          6'b010000, 'h11112222);
        tbl[8]  = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);
        tbl[9]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);
        tbl[10] = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);
        tbl[11] = mk(1, 1, 0, 'h10,  0, 1, 1, 'h30,  'h0000A5A5, 6'b000010, 0);
        tbl[12] = mk(1, 1, 0, 'h10,  0, 1, 1, 'h30,  'h0000A5A5, 6'b100010, 0);
        tbl[13] = mk(1, 1, 0, 'h10,  0, 1, 1, 'h30,  'h0000A5A5, 6'b010000, 'hDEADBEEF);
        tbl[14] = mk(1, 1, 0, 'h14,  0, 1, 1, 'h30,  'h0000A5A5, 6'b001011, 0);
        tbl[15] = mk(1, 1, 0, 'h14,  0, 1, 1, 'h30,  'h0000A5A5, 6'b000110, 0);
        tbl[16] = mk(1, 1, 0, 'h14,  0, 1, 0, 'h30,  0,          6'b100010, 0);
        tbl[17] = mk(1, 1, 0, 'h14,  0, 1, 0, 'h30,  0,          6'b010000, 'h11112222);
        tbl[18] = mk(1, 1, 0, 'h10,  0, 1, 0, 'h30,  0,          6'b001010, 0);
        tbl[19] = mk(1, 1, 0, 'h10,  0, 1, 0, 'h30,  0,          6'b000110, 'h0000A5A5);
        tbl[20] = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b100000, 0);
        tbl[21] = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b010000, 'hDEADBEEF);
        tbl[22] = mk(1, 0, 0, 0,     0, 0, 0, 0,     0,          6'b000000, 0);

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_u1_outs", 64'({u1_a_gnt, u1_a_ack, u1_b_gnt, u1_b_ack, u1_mw}), 64'd0);
        chk("rst_u1_mem", 64'({u1_maddr, u1_mwdata}), 64'd0);
        chk("rst_u1_rdata", 64'({u1_a_rdata, u1_b_rdata}), 64'd0);
        chk("rst_u3_outs", 64'({u3_a_gnt, u3_a_ack, u3_b_gnt, u3_b_ack, u3_mw}), 64'd0);

        // MEM_LATENCY=1 vector table
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            reset = tbl[i].rst;
            a_req = tbl[i].a_req; a_we = tbl[i].a_we;
            a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
            b_req = tbl[i].b_req; b_we = tbl[i].b_we;
            b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
            #1;
            got = {u1_a_gnt, u1_a_ack, u1_b_gnt, u1_b_ack, u1_core_stall, u1_mw};
            chk($sformatf("vec%0d_ctl", i), 64'(got), 64'(tbl[i].exp));
            if (tbl[i].exp[4]) chk($sformatf("vec%0d_a_rdata", i), 64'(u1_a_rdata), 64'(tbl[i].exp_rdata));
            if (tbl[i].exp[2]) chk($sformatf("vec%0d_b_rdata", i), 64'(u1_b_rdata), 64'(tbl[i].exp_rdata));
        end

        // MEM_LATENCY=3: fresh reset, then B write, A read-back
        @(negedge clock); reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        run3(1'b1, 1'b1, 32'h20, 32'h0000CAFE, ack_k, nw, ng, mwk);
        chk("l3_wr_ack_cycle", 64'(ack_k), 64'd4);
        chk("l3_wr_strobes", 64'(nw), 64'd1);
        chk("l3_wr_strobe_cycle", 64'(mwk), 64'd1);
        chk("l3_wr_gnt_cycles", 64'(ng), 64'd3);
        chk("l3_wr_b_rdata", 64'(u3_b_rdata), 64'd0);
        run3(1'b0, 1'b0, 32'h20, 32'h0, ack_k, nw, ng, mwk);
        chk("l3_rd_ack_cycle", 64'(ack_k), 64'd4);
        chk("l3_rd_strobes", 64'(nw), 64'd0);
        chk("l3_rd_data", 64'(u3_a_rdata), 64'h0000CAFE);
        repeat (3) @(negedge clock);
        #1;
        chk("l3_rdata_hold", 64'(u3_a_rdata), 64'h0000CAFE);

        // Reset during the second BUSY_A cycle (last winner was A)
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 32'h20;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("mid_busy_gnt", 64'(u3_a_gnt), 64'd1);
        reset = 0;
        @(negedge clock);
        #1;
        chk("abort_outs", 64'({u3_a_gnt, u3_a_ack, u3_b_gnt, u3_b_ack, u3_mw}), 64'd0);
        chk("abort_mem", 64'({u3_maddr, u3_mwdata}), 64'd0);
        chk("abort_rdata", 64'(u3_a_rdata), 64'd0);
        a_req = 0; reset = 1;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); #1;
            if (u3_a_ack) acks++;
        end
        chk("abort_no_ack", 64'(acks), 64'd0);
        // last_winner back to B: a tie must go to A
        a_req = 1; a_addr = 32'h40; b_req = 1; b_we = 0; b_addr = 32'h44;
        @(negedge clock); #1;
        chk("abort_tie_a_first", 64'({u3_a_gnt, u3_b_gnt}), 64'b10);

        // Perf counters over 4 contended rounds
        reset = 0; a_req = 0; b_req = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        for (int r = 0; r < 4; r++) round3(r);
        @(negedge clock); #1;
`ifdef DMEM_ARBITER_PERF_EN
        chk("perf_a_grants", 64'(u3_pa), 64'd4);
        chk("perf_b_grants", 64'(u3_pb), 64'd4);
        chk("perf_conflicts_ge4", 64'(u3_pc >= 16'd4), 64'd1);
        chk("perf_u1_nonzero", 64'({u1_pa != 0, u1_pb != 0, u1_pc != 0}), 64'b111);
`else
        chk("perf_u3_zero", 64'({u3_pa, u3_pb, u3_pc}), 64'd0);
        chk("perf_u1_zero", 64'({u1_pa, u1_pb, u1_pc}), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
